// File: rtl/dac_sweep_if.sv
// ---------------------------------------------------------------------------
// dac_sweep_if
//   Bundle between the DAC sweep scheduler and its surroundings: the sweep
//   control strobes, the live VGA pixel stream, and the registered DAC pins
//   plus sweep status.
//
//   master : drives start/abort/chan_mask/bias_cfg/vid_*; observes the DAC
//            pins and status (the controller or testbench side)
//   slave  : the scheduler itself
//
//   start       1-cycle request for a calibration sweep
//   abort       level, cancels a running sweep
//   chan_mask   {B,G,R} channels to sweep, sampled on an accepted start
//   bias_cfg    pass-through Vbias code
//   vid_r/g/b   live pixel codes; vid_blank high during H/V blanking
//   dac_r/g/b   registered DAC codes; dac_bias registered Vbias code
//   busy, done, sample_stb, cur_chan, cur_code   sweep status
// ---------------------------------------------------------------------------
interface dac_sweep_if #(
    parameter int CODE_W = 8,
    parameter int BIAS_W = 3
);
    logic              start;
    logic              abort;
    logic [2:0]        chan_mask;
    logic [BIAS_W-1:0] bias_cfg;
    logic [CODE_W-1:0] vid_r;
    logic [CODE_W-1:0] vid_g;
    logic [CODE_W-1:0] vid_b;
    logic              vid_blank;

    logic [CODE_W-1:0] dac_r;
    logic [CODE_W-1:0] dac_g;
    logic [CODE_W-1:0] dac_b;
    logic [BIAS_W-1:0] dac_bias;
    logic              busy;
    logic              done;
    logic              sample_stb;
    logic [1:0]        cur_chan;
    logic [CODE_W-1:0] cur_code;

    modport master (
        output start, abort, chan_mask, bias_cfg, vid_r, vid_g, vid_b, vid_blank,
        input  dac_r, dac_g, dac_b, dac_bias, busy, done, sample_stb, cur_chan, cur_code
    );

    modport slave (
        input  start, abort, chan_mask, bias_cfg, vid_r, vid_g, vid_b, vid_blank,
        output dac_r, dac_g, dac_b, dac_bias, busy, done, sample_stb, cur_chan, cur_code
    );
endinterface

// File: rtl/dac_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// dac_sweep_scheduler
//   Owns the R/G/B DAC codes and the shared Vbias code. Normally passes the
//   live VGA pixel stream straight through (one register stage). On request
//   it runs a calibration sweep: every selected channel ramps 0..255, each
//   code held HOLD_CYCLES clocks, with sample_stb on the last hold cycle.
//   The hand-over to and from the sweep waits for blanking so the switch
//   never lands in active video.
//
//   Ports
//     clk   clock
//     rst   synchronous reset, active-high
//     bus   dac_sweep_if.slave (control, pixel stream, DAC pins, status)
//
//   Build option
//     SWEEP_BIAS_EN  when defined, the whole channel sweep is repeated for
//                    every Vbias code 0..2^BIAS_W-1. When undefined, a single
//                    pass runs and dac_bias always follows bias_cfg.
// ---------------------------------------------------------------------------
module dac_sweep_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int CODE_W      = 8,
    parameter int BIAS_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    dac_sweep_if.slave  bus
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_BLANK = 3'd1,
        SWEEP      = 3'd2,
`ifdef SWEEP_BIAS_EN
        NEXT_BIAS  = 3'd3,
`endif
        RELEASE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] r;
        logic [CODE_W-1:0] g;
        logic [CODE_W-1:0] b;
    } rgb_t;

    state_t            state;
    logic [2:0]        mask_q;
    logic [HOLD_W-1:0] hold_cnt;
    rgb_t              dac_q;
    logic [BIAS_W-1:0] bias_q;
    logic              busy_q;
    logic              done_q;
    logic              stb_q;
    logic [1:0]        cur_chan_q;
    logic [CODE_W-1:0] cur_code_q;
    logic [2:0]        later_chans;

    // Lowest selected channel in R,G,B order.
    function automatic logic [1:0] first_chan(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Only the swept channel carries the code; the other two sit at 0.
    function automatic rgb_t sweep_rgb(input logic [1:0] ch, input logic [CODE_W-1:0] code);
        rgb_t v;
        v = '0;
        case (ch)
            2'd0:    v.r = code;
            2'd1:    v.g = code;
            default: v.b = code;
        endcase
        return v;
    endfunction

    // Begin the first hold cycle of a code. With HOLD_CYCLES == 1 every cycle
    // is also the last hold cycle, so the strobe fires immediately.
    task automatic show_code(input logic [1:0] ch, input logic [CODE_W-1:0] code);
        cur_chan_q <= ch;
        cur_code_q <= code;
        dac_q      <= sweep_rgb(ch, code);
        hold_cnt   <= '0;
        stb_q      <= (HOLD_CYCLES == 1);
    endtask

    // Selected channels strictly after the one currently being swept.
    always_comb begin
        // NOTE: assign a default first so no path leaves the signal unassigned (no latch).
        later_chans = '0;
        later_chans = mask_q & (3'b110 << cur_chan_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            hold_cnt   <= '0;
            dac_q      <= '0;
            bias_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stb_q      <= 1'b0;
            cur_chan_q <= '0;
            cur_code_q <= '0;
        end else begin
            // Outside an explicit override the DAC codes and status fields are
            // 0 (RELEASE, NEXT_BIAS, and the code fields outside SWEEP).
            dac_q      <= '0;
            done_q     <= 1'b0;
            stb_q      <= 1'b0;
            cur_chan_q <= '0;
            cur_code_q <= '0;
`ifndef SWEEP_BIAS_EN
            bias_q     <= bus.bias_cfg;
`endif
            if (state != IDLE && bus.abort) begin
                // Abort wins over every other transition; no done pulse.
                state    <= IDLE;
                busy_q   <= 1'b0;
                hold_cnt <= '0;
                dac_q    <= {bus.vid_r, bus.vid_g, bus.vid_b};
`ifdef SWEEP_BIAS_EN
                bias_q   <= bus.bias_cfg;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        dac_q <= {bus.vid_r, bus.vid_g, bus.vid_b};
`ifdef SWEEP_BIAS_EN
                        bias_q <= bus.bias_cfg;
`endif
                        if (bus.start && (bus.chan_mask != 3'b000)) begin
                            mask_q <= bus.chan_mask;
                            busy_q <= 1'b1;
                            state  <= WAIT_BLANK;
                        end
                    end

                    WAIT_BLANK: begin
                        if (bus.vid_blank) begin
                            state <= SWEEP;
                            show_code(first_chan(mask_q), '0);
`ifdef SWEEP_BIAS_EN
                            bias_q <= '0;
`endif
                        end else begin
                            dac_q <= {bus.vid_r, bus.vid_g, bus.vid_b};
`ifdef SWEEP_BIAS_EN
                            bias_q <= bus.bias_cfg;
`endif
                        end
                    end

                    SWEEP: begin
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt   <= hold_cnt + 1'b1;
                            cur_chan_q <= cur_chan_q;
                            cur_code_q <= cur_code_q;
                            dac_q      <= sweep_rgb(cur_chan_q, cur_code_q);
                            stb_q      <= (HOLD_W'(hold_cnt + 1'b1) == HOLD_LAST);
                        end else if (cur_code_q != CODE_MAX) begin
                            show_code(cur_chan_q, cur_code_q + 1'b1);
                        end else if (later_chans != 3'b000) begin
                            show_code(first_chan(later_chans), '0);
                        end else begin
                            hold_cnt <= '0;
`ifdef SWEEP_BIAS_EN
                            state    <= NEXT_BIAS;
`else
                            state    <= RELEASE;
`endif
                        end
                    end

`ifdef SWEEP_BIAS_EN
                    NEXT_BIAS: begin
                        if (bias_q != '1) begin
                            bias_q <= bias_q + 1'b1;
                            state  <= SWEEP;
                            show_code(first_chan(mask_q), '0);
                        end else begin
                            state <= RELEASE;
                        end
                    end
`endif

                    RELEASE: begin
                        // Codes stay at 0 until blanking; done coincides with busy falling.
                        if (bus.vid_blank) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dac_r      = dac_q.r;
    assign bus.dac_g      = dac_q.g;
    assign bus.dac_b      = dac_q.b;
    assign bus.dac_bias   = bias_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sample_stb = stb_q;
    assign bus.cur_chan   = cur_chan_q;
    assign bus.cur_code   = cur_code_q;

endmodule

// File: tb/tb_dac_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_sweep_scheduler
//   Self-checking bench for dac_sweep_scheduler (HOLD_CYCLES = 2). Expected
//   sweep traces are generated from the sweep rules with nested loops over
//   bias pass / channel / code / hold cycle; pass-through expectations are the
//   pixel values applied one clock earlier. Works with SWEEP_BIAS_EN defined
//   or undefined.
// ---------------------------------------------------------------------------
module tb_dac_sweep_scheduler;

    localparam int HOLD = 2;
`ifdef SWEEP_BIAS_EN
    localparam int BIAS_PASSES = 8;
    localparam bit BIAS_EN     = 1'b1;
`else
    localparam int BIAS_PASSES = 1;
    localparam bit BIAS_EN     = 1'b0;
`endif

    localparam int K_NONE  = 0;
    localparam int K_START = 1;
    localparam int K_ABORT = 2;
    localparam int K_RST   = 3;

    logic clk = 1'b0;
    logic rst;

    dac_sweep_if #(.CODE_W(8), .BIAS_W(3)) bus ();

    dac_sweep_scheduler #(
        .HOLD_CYCLES (HOLD),
        .CODE_W      (8),
        .BIAS_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [7:0] r, g, b;
        logic [2:0] bias;
        logic       blank;
        logic [7:0] er, eg, eb;
        logic [2:0] ebias;
    } pt_vec_t;

    pt_vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output snapshot: {busy, done, stb, chan, code, r, g, b, bias}
    function automatic logic [63:0] pack(input logic busy, input logic done, input logic stb,
                                         input logic [1:0] ch, input logic [7:0] code,
                                         input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic [2:0] bias);
        return {24'd0, busy, done, stb, ch, code, r, g, b, bias};
    endfunction

    function automatic logic [63:0] observed();
        return pack(bus.busy, bus.done, bus.sample_stb, bus.cur_chan, bus.cur_code,
                    bus.dac_r, bus.dac_g, bus.dac_b, bus.dac_bias);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pass-through cycle with fresh random pixels.
    task automatic step_pt(input string name, input logic exp_busy);
        logic [7:0] r, g, b;
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        bus.vid_r = r;
        bus.vid_g = g;
        bus.vid_b = b;
        tick();
        check(name, observed(), pack(exp_busy, 1'b0, 1'b0, 2'd0, 8'd0, r, g, b, bus.bias_cfg));
    endtask

    // Expected visible trace from the first sweep cycle to the last cycle before RELEASE.
    task automatic build_expected(input logic [2:0] mask, input logic [2:0] cfg_bias);
        logic [2:0] bias;
        exp_q.delete();
        for (int p = 0; p < BIAS_PASSES; p++) begin
            bias = BIAS_EN ? 3'(p) : cfg_bias;
            for (int ch = 0; ch < 3; ch++) begin
                if (mask[ch]) begin
                    for (int code = 0; code < 256; code++) begin
                        for (int h = 0; h < HOLD; h++) begin
                            exp_q.push_back(pack(1'b1, 1'b0, (h == HOLD - 1), 2'(ch), 8'(code),
                                                 (ch == 0) ? 8'(code) : 8'd0,
                                                 (ch == 1) ? 8'(code) : 8'd0,
                                                 (ch == 2) ? 8'(code) : 8'd0, bias));
                        end
                    end
                end
            end
            // One bias-step cycle with codes parked at 0 after every pass.
            if (BIAS_EN) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, bias));
        end
    endtask

    task automatic run_sweep(input string tag, input logic [2:0] mask, input int wait_n,
                             input int stop_at, input int stop_kind);
        int         stb_seen;
        logic [2:0] rel_bias;
        logic [7:0] r, g, b;
        stb_seen = 0;
        build_expected(mask, bus.bias_cfg);

        bus.vid_blank = 1'b0;
        bus.chan_mask = mask;
        bus.start     = 1'b1;
        step_pt({tag, " accept"}, 1'b1);
        bus.start     = 1'b0;
        bus.chan_mask = 3'($urandom);
        for (int i = 0; i < wait_n; i++) step_pt({tag, " wait_blank"}, 1'b1);

        for (int i = 0; i < exp_q.size(); i++) begin
            bus.vid_blank = (i == 0);
            bus.start     = 1'b0;
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            bus.vid_r = r;
            bus.vid_g = g;
            bus.vid_b = b;
            if (i == stop_at) begin
                case (stop_kind)
                    K_ABORT: begin
                        bus.abort = 1'b1;
                        tick();
                        check({tag, " abort"}, observed(),
                              pack(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, r, g, b, bus.bias_cfg));
                        bus.abort = 1'b0;
                        step_pt({tag, " after abort"}, 1'b0);
                        step_pt({tag, " after abort"}, 1'b0);
                        return;
                    end
                    K_RST: begin
                        rst = 1'b1;
                        tick();
                        check({tag, " sync reset"}, observed(), 64'd0);
                        rst = 1'b0;
                        step_pt({tag, " after reset"}, 1'b0);
                        return;
                    end
                    K_START: begin
                        bus.start     = 1'b1;
                        bus.chan_mask = 3'b111;
                    end
                    default: ;
                endcase
            end
            tick();
            if (bus.sample_stb) stb_seen++;
            check({tag, " sweep"}, observed(), exp_q[i]);
        end
        bus.start     = 1'b0;
        bus.vid_blank = 1'b0;
        check({tag, " strobe count"}, 64'(stb_seen), 64'($countones(mask) * 256 * BIAS_PASSES));

        rel_bias = BIAS_EN ? 3'd7 : bus.bias_cfg;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, " release"}, observed(),
                  pack(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, rel_bias));
        end
        bus.vid_blank = 1'b1;
        tick();
        check({tag, " done"}, observed(),
              pack(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, rel_bias));
        bus.vid_blank = 1'b0;
        step_pt({tag, " resume"}, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'h00, 3'd5, 1'b0, 8'hA5, 8'h3C, 8'h00, 3'd5};
        vecs[1] = '{8'hFF, 8'h00, 8'h80, 3'd7, 1'b1, 8'hFF, 8'h00, 8'h80, 3'd7};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 8'hFF, 8'h01, 3'd0};
        vecs[3] = '{8'h5A, 8'hC3, 8'hFE, 3'd2, 1'b1, 8'h5A, 8'hC3, 8'hFE, 3'd2};
        vecs[4] = '{8'h12, 8'h34, 8'h56, 3'd6, 1'b0, 8'h12, 8'h34, 8'h56, 3'd6};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.chan_mask = 3'b111;
        bus.bias_cfg  = 3'd5;
        bus.vid_r     = 8'hA5;
        bus.vid_g     = 8'h3C;
        bus.vid_b     = 8'h77;
        bus.vid_blank = 1'b1;
        tick();
        tick();
        check("reset", observed(), 64'd0);
        rst = 1'b0;

        // Pass-through vectors: one-cycle latency, busy low.
        foreach (vecs[k]) begin
            bus.vid_r     = vecs[k].r;
            bus.vid_g     = vecs[k].g;
            bus.vid_b     = vecs[k].b;
            bus.bias_cfg  = vecs[k].bias;
            bus.vid_blank = vecs[k].blank;
            tick();
            check("pass-through vector", observed(),
                  pack(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, vecs[k].er, vecs[k].eg, vecs[k].eb, vecs[k].ebias));
        end

        for (int i = 0; i < 16; i++) begin
            bus.bias_cfg  = 3'($urandom);
            bus.vid_blank = 1'($urandom);
            step_pt("pass-through random", 1'b0);
        end

        // Ignored requests in IDLE.
        bus.vid_blank = 1'b0;
        bus.chan_mask = 3'b000;
        bus.start     = 1'b1;
        step_pt("start mask0", 1'b0);
        bus.start     = 1'b0;
        step_pt("start mask0 idle", 1'b0);
        bus.abort     = 1'b1;
        step_pt("abort in idle", 1'b0);
        step_pt("abort in idle", 1'b0);
        bus.abort     = 1'b0;

        bus.bias_cfg = 3'd5;
        run_sweep("single_g", 3'b010, 5, 300, K_START);
        run_sweep("r_then_b", 3'b101, 0, -1, K_NONE);

        // abort + start together in WAIT_BLANK, with blanking present.
        bus.chan_mask = 3'b011;
        bus.start     = 1'b1;
        step_pt("collide accept", 1'b1);
        bus.abort     = 1'b1;
        bus.vid_blank = 1'b1;
        step_pt("collide abort", 1'b0);
        bus.abort     = 1'b0;
        bus.start     = 1'b0;
        bus.vid_blank = 1'b0;
        step_pt("collide idle", 1'b0);

        run_sweep("abort_r100", 3'b101, 2, 100 * HOLD + 1, K_ABORT);
        run_sweep("rst_r200", 3'b001, 1, 200 * HOLD + 1, K_RST);

        for (int n = 0; n < 2; n++) begin
            bus.bias_cfg = 3'($urandom);
            run_sweep("random", 3'($urandom_range(7, 1)), int'($urandom_range(6, 0)), -1, K_NONE);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
